// File: rtl/floo_narrow_cfg_seq.sv
// floo_narrow_cfg_seq: single-outstanding AXI4 configuration sequencer.
// Turns a command stream (addr/data/strb/write) into single-beat AXI4
// transactions on the cluster narrow slave link and returns each completion
// on a response stream.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   cmd_*                     command stream in (valid/ready, write, addr, data, strb)
//   rsp_*                     response stream out (valid/ready, data, resp, timeout)
//   axi_req_o / axi_rsp_i     narrow AXI4 link to/from the cluster
//   busy_o                    high whenever the sequencer is not idle
//   txn_cnt_o                 accepted-command counter, wraps at 2^16
//
// Optional feature: define FLOO_CFG_SEQ_TIMEOUT_EN to abandon a transaction
// after TimeoutCycles in a wait state (rsp_timeout_o = 1, resp = SLVERR).

package floo_narrow_cfg_seq_pkg;
  localparam int unsigned AxiAddrWidth = 48;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiIdWidth   = 6;
  localparam int unsigned AxiUserWidth = 1;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [5:0]              atop;
    logic [AxiUserWidth-1:0] user;
  } axi_narrow_in_aw_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserWidth-1:0]   user;
  } axi_narrow_in_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [AxiUserWidth-1:0] user;
  } axi_narrow_in_b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [AxiUserWidth-1:0] user;
  } axi_narrow_in_ar_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [AxiUserWidth-1:0] user;
  } axi_narrow_in_r_chan_t;

  typedef struct packed {
    axi_narrow_in_aw_chan_t aw;
    logic                   aw_valid;
    axi_narrow_in_w_chan_t  w;
    logic                   w_valid;
    logic                   b_ready;
    axi_narrow_in_ar_chan_t ar;
    logic                   ar_valid;
    logic                   r_ready;
  } axi_narrow_in_req_t;

  typedef struct packed {
    logic                  aw_ready;
    logic                  ar_ready;
    logic                  w_ready;
    logic                  b_valid;
    axi_narrow_in_b_chan_t b;
    logic                  r_valid;
    axi_narrow_in_r_chan_t r;
  } axi_narrow_in_rsp_t;
endpackage

module floo_narrow_cfg_seq
  import floo_narrow_cfg_seq_pkg::*;
#(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [DataWidth-1:0]   cmd_data_i,
  input  logic [DataWidth/8-1:0] cmd_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_data_o,
  output logic [1:0]             rsp_resp_o,
  output logic                   rsp_timeout_o,
  output axi_narrow_in_req_t     axi_req_o,
  input  axi_narrow_in_rsp_t     axi_rsp_i,
  output logic                   busy_o,
  output logic [15:0]            txn_cnt_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [2:0]  AxSize    = 3'($clog2(StrbWidth));

  if (TimeoutCycles < 2 || DataWidth < 8 || AxiIdWidth < IdWidth ||
      AxiDataWidth != DataWidth || AxiAddrWidth != AddrWidth) begin : g_bad_cfg
    $error("floo_narrow_cfg_seq: unsupported parameter combination");
  end

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_WAIT, RD_ADDR, RD_WAIT, RSP} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]   strb_q, strb_d;
  logic [IdWidth-1:0]     cur_id_q, cur_id_d;
  logic [15:0]            txn_cnt_q, txn_cnt_d;
  logic                   aw_pend_q, aw_pend_d;
  logic                   w_pend_q, w_pend_d;
  logic [DataWidth-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]             rsp_resp_q, rsp_resp_d;
  logic                   b_match, r_match;
  logic                   unused_rsp;

`ifdef FLOO_CFG_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            tmo_hit;
`endif

  // Only the matching, correctly-timed beat completes; everything else is sunk.
  assign b_match = (state_q == WR_WAIT) && axi_rsp_i.b_valid &&
                   (axi_rsp_i.b.id == AxiIdWidth'(cur_id_q));
  assign r_match = (state_q == RD_WAIT) && axi_rsp_i.r_valid && axi_rsp_i.r.last &&
                   (axi_rsp_i.r.id == AxiIdWidth'(cur_id_q));
  assign unused_rsp = ^axi_rsp_i;

`ifdef FLOO_CFG_SEQ_TIMEOUT_EN
  // Counter is zero on wait-state entry because it is cleared everywhere else.
  assign tmo_hit = (tmo_cnt_q == TmoW'(TimeoutCycles - 1));
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == WR_WAIT || state_q == RD_WAIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    cur_id_d   = cur_id_q;
    txn_cnt_d  = txn_cnt_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;
`ifdef FLOO_CFG_SEQ_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d    = cmd_addr_i;
          wdata_d   = cmd_data_i;
          strb_d    = cmd_strb_i;
          cur_id_d  = txn_cnt_q[IdWidth-1:0];
          txn_cnt_d = txn_cnt_q + 16'd1;
          if (cmd_write_i) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        aw_pend_d = aw_pend_q & ~axi_rsp_i.aw_ready;
        w_pend_d  = w_pend_q & ~axi_rsp_i.w_ready;
        if (!aw_pend_d && !w_pend_d) state_d = WR_WAIT;
      end
      RD_ADDR: begin
        if (axi_rsp_i.ar_ready) state_d = RD_WAIT;
      end
      WR_WAIT, RD_WAIT: begin
        if (b_match) begin
          rsp_resp_d = axi_rsp_i.b.resp;
          rsp_data_d = '0;
`ifdef FLOO_CFG_SEQ_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d = RSP;
        end else if (r_match) begin
          rsp_resp_d = axi_rsp_i.r.resp;
          rsp_data_d = DataWidth'(axi_rsp_i.r.data);
`ifdef FLOO_CFG_SEQ_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d = RSP;
        end
`ifdef FLOO_CFG_SEQ_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_resp_d    = 2'b10;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = RSP;
        end
`endif
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      cur_id_q   <= '0;
      txn_cnt_q  <= '0;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= '0;
`ifdef FLOO_CFG_SEQ_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      cur_id_q   <= cur_id_d;
      txn_cnt_q  <= txn_cnt_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
`ifdef FLOO_CFG_SEQ_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  // Handshake-visible outputs are forced low while reset is held.
  assign cmd_ready_o = (state_q == IDLE) && !rst_i;
  assign busy_o      = (state_q != IDLE) && !rst_i;
  assign rsp_valid_o = (state_q == RSP) && !rst_i;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_resp_o  = rsp_resp_q;
  assign txn_cnt_o   = txn_cnt_q;
`ifdef FLOO_CFG_SEQ_TIMEOUT_EN
  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AxiIdWidth'(cur_id_q);
    axi_req_o.aw.addr  = AxiAddrWidth'(addr_q);
    axi_req_o.aw.size  = AxSize;
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.aw_valid = aw_pend_q && !rst_i;
    axi_req_o.w.data   = AxiDataWidth'(wdata_q);
    axi_req_o.w.strb   = (AxiDataWidth/8)'(strb_q);
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_pend_q && !rst_i;
    axi_req_o.b_ready  = 1'b1;
    axi_req_o.ar.id    = AxiIdWidth'(cur_id_q);
    axi_req_o.ar.addr  = AxiAddrWidth'(addr_q);
    axi_req_o.ar.size  = AxSize;
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.ar_valid = (state_q == RD_ADDR) && !rst_i;
    axi_req_o.r_ready  = 1'b1;
  end

endmodule

// File: tb/tb_floo_narrow_cfg_seq.sv
// Directed testbench for floo_narrow_cfg_seq. Inputs change on the falling
// edge, outputs are checked on the falling edge; the AXI slave side is driven
// by hand from the stimulus sequence.
module tb_floo_narrow_cfg_seq;
  import floo_narrow_cfg_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid, cmd_ready, cmd_write;
  logic [47:0]        cmd_addr;
  logic [63:0]        cmd_data;
  logic [7:0]         cmd_strb;
  logic               rsp_valid, rsp_ready, rsp_timeout;
  logic [63:0]        rsp_data;
  logic [1:0]         rsp_resp;
  axi_narrow_in_req_t axi_req;
  axi_narrow_in_rsp_t axi_rsp;
  logic               busy;
  logic [15:0]        txn_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int aw_hs = 0, w_hs = 0, rsp_hs = 0;

  always #5 clk = ~clk;

  floo_narrow_cfg_seq #(
    .AddrWidth(48), .DataWidth(64), .IdWidth(4), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout),
    .axi_req_o(axi_req), .axi_rsp_i(axi_rsp),
    .busy_o(busy), .txn_cnt_o(txn_cnt)
  );

  // Handshake counters for detecting reissued or duplicated beats.
  always @(posedge clk) begin
    if (!rst) begin
      if (axi_req.aw_valid && axi_rsp.aw_ready) aw_hs <= aw_hs + 1;
      if (axi_req.w_valid && axi_rsp.w_ready) w_hs <= w_hs + 1;
      if (rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents one command for a single cycle; returns at the negedge of cycle 1.
  task automatic send(input logic wr, input logic [47:0] a, input logic [63:0] d,
                      input logic [7:0] s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_strb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic b_beat(input logic [5:0] id, input logic [1:0] resp);
    axi_rsp.b_valid = 1'b1; axi_rsp.b.id = id; axi_rsp.b.resp = resp;
  endtask

  task automatic r_beat(input logic [5:0] id, input logic [63:0] d, input logic last);
    axi_rsp.r_valid = 1'b1; axi_rsp.r.id = id; axi_rsp.r.data = d;
    axi_rsp.r.last = last; axi_rsp.r.resp = 2'b00;
  endtask

  task automatic clear_beats();
    axi_rsp.b_valid = 1'b0; axi_rsp.r_valid = 1'b0;
  endtask

  int aw0, w0, r0;
  logic seen_ready;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_strb = '0; rsp_ready = 1'b0; axi_rsp = '0;
    tick(); tick();
    // ---- reset state
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_aw_valid", axi_req.aw_valid, 0);
    check("rst_txn_cnt", txn_cnt, 0);
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("b_ready_const", axi_req.b_ready, 1);
    check("r_ready_const", axi_req.r_ready, 1);

    // ---- write, always-ready slave (id 0)
    axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1; axi_rsp.ar_ready = 1'b1;
    rsp_ready = 1'b1;
    send(1'b1, 48'h1000, 64'hDEAD_BEEF, 8'hFF);
    check("wr_aw_valid", axi_req.aw_valid, 1);
    check("wr_w_valid", axi_req.w_valid, 1);
    check("wr_aw_addr", axi_req.aw.addr, 64'h1000);
    check("wr_aw_len", axi_req.aw.len, 0);
    check("wr_aw_size", axi_req.aw.size, 3);
    check("wr_aw_burst", axi_req.aw.burst, 1);
    check("wr_aw_id", axi_req.aw.id, 0);
    check("wr_w_data", axi_req.w.data, 64'hDEAD_BEEF);
    check("wr_w_strb", axi_req.w.strb, 8'hFF);
    check("wr_w_last", axi_req.w.last, 1);
    check("wr_cmd_ready_busy", cmd_ready, 0);
    tick(); // cycle 2: WR_WAIT
    check("wr_aw_dropped", axi_req.aw_valid, 0);
    check("wr_w_dropped", axi_req.w_valid, 0);
    b_beat(6'd0, 2'b00);
    tick(); // cycle 3
    clear_beats();
    check("wr_rsp_valid_c3", rsp_valid, 1);
    check("wr_rsp_resp", rsp_resp, 0);
    check("wr_rsp_data", rsp_data, 0);
    check("wr_rsp_timeout", rsp_timeout, 0);
    check("wr_txn_cnt", txn_cnt, 1);
    tick(); // cycle 4
    check("wr_cmd_ready_c4", cmd_ready, 1);
    check("wr_aw_hs", aw_hs, 1);
    check("wr_w_hs", w_hs, 1);

    // ---- read with 10-cycle slave delay (id 1)
    send(1'b0, 48'h2008, 64'h0, 8'h00);
    check("rd_ar_valid", axi_req.ar_valid, 1);
    check("rd_ar_addr", axi_req.ar.addr, 64'h2008);
    check("rd_ar_id", axi_req.ar.id, 1);
    check("rd_ar_size", axi_req.ar.size, 3);
    tick(); // RD_WAIT
    check("rd_ar_dropped", axi_req.ar_valid, 0);
    seen_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready || rsp_valid) seen_ready = 1'b1;
      tick();
    end
    check("rd_wait_no_ready", seen_ready, 0);
    rsp_ready = 1'b0;
    r_beat(6'd1, 64'h1234, 1'b1);
    tick();
    clear_beats();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_data", rsp_data, 64'h1234);
    check("rd_rsp_resp", rsp_resp, 0);
    check("rd_cmd_ready_in_rsp", cmd_ready, 0);
    rsp_ready = 1'b1;
    tick();
    check("rd_back_idle", cmd_ready, 1);
    check("rd_txn_cnt", txn_cnt, 2);

    // ---- AW/W skew: W first (id 2)
    aw0 = aw_hs; w0 = w_hs; r0 = rsp_hs;
    axi_rsp.aw_ready = 1'b0;
    send(1'b1, 48'h3000, 64'hA5A5, 8'h0F);
    for (int i = 0; i < 5; i++) tick();
    check("skew1_w_done", axi_req.w_valid, 0);
    check("skew1_aw_held", axi_req.aw_valid, 1);
    axi_rsp.aw_ready = 1'b1;
    tick(); // WR_WAIT
    b_beat(6'd2, 2'b00);
    tick();
    clear_beats();
    check("skew1_rsp_valid", rsp_valid, 1);
    tick();
    check("skew1_aw_once", aw_hs - aw0, 1);
    check("skew1_w_once", w_hs - w0, 1);
    check("skew1_rsp_once", rsp_hs - r0, 1);

    // ---- AW/W skew: AW first (id 3)
    aw0 = aw_hs; w0 = w_hs; r0 = rsp_hs;
    axi_rsp.w_ready = 1'b0;
    send(1'b1, 48'h3008, 64'h5A5A, 8'hF0);
    for (int i = 0; i < 5; i++) tick();
    check("skew2_aw_done", axi_req.aw_valid, 0);
    check("skew2_w_held", axi_req.w_valid, 1);
    axi_rsp.w_ready = 1'b1;
    tick();
    b_beat(6'd3, 2'b00);
    tick();
    clear_beats();
    check("skew2_rsp_valid", rsp_valid, 1);
    tick();
    check("skew2_aw_once", aw_hs - aw0, 1);
    check("skew2_w_once", w_hs - w0, 1);
    check("skew2_rsp_once", rsp_hs - r0, 1);

    // ---- stray B, SLVERR with simultaneous stray R, back-pressure (id 4)
    send(1'b1, 48'h4000, 64'h1, 8'h01);
    tick(); // WR_WAIT
    b_beat(6'd7, 2'b00);
    tick();
    check("stray_b_dropped", rsp_valid, 0);
    check("stray_b_busy", busy, 1);
    b_beat(6'd4, 2'b10);
    r_beat(6'd4, 64'hFFFF, 1'b1);
    rsp_ready = 1'b0;
    tick();
    clear_beats();
    check("slverr_rsp_valid", rsp_valid, 1);
    check("slverr_resp", rsp_resp, 2'b10);
    check("slverr_stray_r_data", rsp_data, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_resp", rsp_resp, 2'b10);
      check("bp_rsp_data", rsp_data, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_released", cmd_ready, 1);
    check("bp_txn_cnt", txn_cnt, 5);

`ifdef FLOO_CFG_SEQ_TIMEOUT_EN
    // ---- timeout (id 5), late B during next read (id 6)
    send(1'b1, 48'h5000, 64'h2, 8'h01);
    tick(); // WR_WAIT entry
    for (int i = 0; i < 15; i++) tick();
    check("tmo_not_yet", rsp_valid, 0);
    rsp_ready = 1'b0;
    tick(); // entry + 16
    check("tmo_rsp_valid", rsp_valid, 1);
    check("tmo_flag", rsp_timeout, 1);
    check("tmo_resp", rsp_resp, 2'b10);
    check("tmo_data", rsp_data, 0);
    rsp_ready = 1'b1;
    tick();
    send(1'b0, 48'h6000, 64'h0, 8'h00);
    tick(); // RD_WAIT
    b_beat(6'd5, 2'b00);
    tick();
    clear_beats();
    check("late_b_dropped", rsp_valid, 0);
    r_beat(6'd6, 64'h66, 1'b1);
    tick();
    clear_beats();
    check("after_tmo_rsp_valid", rsp_valid, 1);
    check("after_tmo_data", rsp_data, 64'h66);
    check("after_tmo_flag", rsp_timeout, 0);
    tick();
`endif

    // ---- reset while in RD_ADDR
    axi_rsp.ar_ready = 1'b0;
    send(1'b0, 48'h7000, 64'h0, 8'h00);
    check("mid_ar_valid", axi_req.ar_valid, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_ar_valid", axi_req.ar_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_txn_cnt", txn_cnt, 0);
    rst = 1'b0;
    tick();
    check("mid_rst_idle", cmd_ready, 1);
    check("mid_rst_ar_stays_low", axi_req.ar_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end
endmodule
